duck_round_ctl: RTL
===================

# duck_round_ctl

Game-round sequencer for the duck-shooting screen. It turns raw mouse presses and the per-pixel hit flag from the click detector into shots, hits, misses, rounds and a score. It sits between the mouse/click-detection path and the drawing/score-display modules, and tells the duck renderer when to respawn.

## Interface
Parameters:
- SHOTS, 3: shots per round (1..3)
- ROUNDS, 10: rounds per game (1..15)
- EVAL_FRAMES, 2: frame ticks a shot stays open for hit detection (1..7)
- HOLD_FRAMES, 30: frames spent in HIT/MISS display (1..63)
- TIMEOUT_FRAMES, 300: frames allowed per round, only used with the timeout feature (1..1023)

Ports:
- pclk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that starts a game
- frame_tick  in  1  one-cycle pulse, once per frame
- mouse_left  in  1  left button level
- rect_clicked  in  1  hit flag from the click detector; level, cleared when the button is released
- state  out  3  current FSM state
- shots_left  out  2  shots remaining in the current round
- round_num  out  4  current round, 1-based; 0 in IDLE
- score  out  8  hits this game, saturates at 255
- miss_cnt  out  4  missed rounds this game
- hit_flash  out  1  high while in HIT
- duck_respawn  out  1  one-cycle pulse when a round begins
- game_over  out  1  high while in GAME_OVER

## Operation
- States (package encoding): IDLE=0, ARMED=1, EVAL=2, HIT=3, MISS=4, GAME_OVER=5.
- Shot edge: mouse_left & ~mouse_prev. mouse_prev is a register that resets to 0.
- IDLE: on start, load score=0, miss_cnt=0, round_num=1, shots_left=SHOTS, pulse duck_respawn, go to ARMED.
- ARMED: on a shot edge, decrement shots_left, clear frame_cnt, go to EVAL.
- EVAL: if rect_clicked=1 in any cycle, increment score (saturating) and go to HIT. Otherwise, when frame_cnt reaches EVAL_FRAMES:
  - shots_left>0: go to ARMED.
  - shots_left=0: go to MISS and increment miss_cnt (saturating at 15).
- Shot edges in EVAL, HIT and MISS are ignored; no new shot starts.
- HIT/MISS: stay until HOLD_FRAMES frame ticks have been counted. Then start the next round:
  - round_num=ROUNDS: go to GAME_OVER.
  - Otherwise: increment round_num, reload shots_left, pulse duck_respawn, go to ARMED.
- GAME_OVER: counters are held. On start, reload exactly as from IDLE.
- start is ignored in ARMED, EVAL, HIT and MISS.
- Boundary cases:
  - rect_clicked and the final frame_tick in the same EVAL cycle: the hit wins.
  - A button held through start produces no shot until it is released and pressed again.

## Timing
- Reset: state=IDLE. All outputs are 0: shots_left, round_num, score, miss_cnt, hit_flash, duck_respawn, game_over. Internal counters and mouse_prev are also 0.
- Reset mid-game aborts everything immediately. The next cycle is IDLE with zeroed outputs.
- All outputs are registered.
- Shot edge in cycle N: state=EVAL and shots_left decremented at N+1.
- rect_clicked=1 in cycle N while in EVAL: state=HIT, hit_flash=1 and score+1 at N+1.
- duck_respawn is high for exactly the one cycle in which state becomes ARMED at the start of a round.
- Frame counting: frame_cnt increments on frame_tick. A transition fires in the cycle of the tick that makes the count equal the limit.

## Configuration
- DUCK_ROUND_TIMEOUT_EN defined:
  - A round counter clears on duck_respawn and counts frame_tick in ARMED and EVAL.
  - When it reaches TIMEOUT_FRAMES while in ARMED, go to MISS (miss_cnt+1) and forfeit the remaining shots.
  - A shot edge in the same cycle wins over the timeout.
  - In EVAL the timeout is deferred until the evaluation resolves.
- Not defined: the counter is absent and ARMED waits indefinitely.

## Structure
- Shared package duck_pkg:
  - State encoding localparams.
  - Width constants: SCORE_W=8, ROUND_W=4, SHOT_W=2.
- One sub-module, rise_detect: registered previous level plus edge pulse. Used for the mouse_left shot edge.
- FSM, counters and next-state logic live in duck_round_ctl in the usual _nxt style.

## Test plan
- Reset, then start → round_num=1, shots_left=3, duck_respawn pulses once, state=ARMED.
- Press; rect_clicked=1 two cycles later → HIT, score=1. After 30 ticks → round_num=2, shots_left=3.
- Three presses, rect_clicked never set, 2 ticks each → shots_left 2, 1, 0; then MISS, miss_cnt=1.
- With ROUNDS=2, hit in both rounds → GAME_OVER, game_over=1, score=2. Start → score=0, round_num=1.
- rect_clicked and the 2nd tick in the same cycle → HIT, not ARMED. Reset asserted in HIT → next cycle IDLE, all outputs 0.
- DUCK_ROUND_TIMEOUT_EN with TIMEOUT_FRAMES=5: no press for 5 ticks → MISS, miss_cnt=1. Press coincident with the 5th tick → EVAL.

Source files
------------

// File: rtl/duck_pkg.sv
// Shared state encoding and width constants for the duck-shooting round sequencer.
package duck_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ARMED     = 3'd1;
    localparam logic [2:0] ST_EVAL      = 3'd2;
    localparam logic [2:0] ST_HIT       = 3'd3;
    localparam logic [2:0] ST_MISS      = 3'd4;
    localparam logic [2:0] ST_GAME_OVER = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_ARMED     = ST_ARMED,
        S_EVAL      = ST_EVAL,
        S_HIT       = ST_HIT,
        S_MISS      = ST_MISS,
        S_GAME_OVER = ST_GAME_OVER
    } state_t;

    localparam int SCORE_W = 8;
    localparam int ROUND_W = 4;
    localparam int SHOT_W  = 2;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registers the previous level and flags a 0->1 transition.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/duck_round_ctl.sv
// Duck-shooting game-round sequencer: shots, hits, misses, rounds and score.
// Optional per-round timeout enabled by defining DUCK_ROUND_TIMEOUT_EN.
module duck_round_ctl
    import duck_pkg::*;
#(
    parameter int SHOTS          = 3,
    parameter int ROUNDS         = 10,
    parameter int EVAL_FRAMES    = 2,
    parameter int HOLD_FRAMES    = 30,
    parameter int TIMEOUT_FRAMES = 300
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               mouse_left,
    input  logic               rect_clicked,
    output logic [2:0]         state,
    output logic [SHOT_W-1:0]  shots_left,
    output logic [ROUND_W-1:0] round_num,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         miss_cnt,
    output logic               hit_flash,
    output logic               duck_respawn,
    output logic               game_over
);

    localparam logic [SHOT_W-1:0]  SHOTS_L  = SHOT_W'(SHOTS);
    localparam logic [ROUND_W-1:0] ROUNDS_L = ROUND_W'(ROUNDS);
    localparam logic [5:0]         EVAL_L   = 6'(EVAL_FRAMES);
    localparam logic [5:0]         HOLD_L   = 6'(HOLD_FRAMES);

    function automatic logic [SCORE_W-1:0] sat_inc_score(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    function automatic logic [3:0] sat_inc_miss(input logic [3:0] v);
        return (&v) ? v : v + 4'd1;
    endfunction

    state_t             st, st_nxt;
    logic [SHOT_W-1:0]  shots_nxt;
    logic [ROUND_W-1:0] round_nxt;
    logic [SCORE_W-1:0] score_nxt;
    logic [3:0]         miss_nxt;
    logic               respawn_nxt;
    logic [5:0]         fcnt, fcnt_inc, fcnt_nxt;
    logic               shot;
    logic               timed_out;

    rise_detect u_shot_edge (
        .clk   (pclk),
        .rst   (rst),
        .level (mouse_left),
        .rise  (shot)
    );

    assign fcnt_inc = frame_tick ? fcnt + 6'd1 : fcnt;

`ifdef DUCK_ROUND_TIMEOUT_EN
    localparam logic [9:0] TO_L = 10'(TIMEOUT_FRAMES);
    logic [9:0] rcnt, rcnt_tick;

    // Round counter saturates at the limit so a timeout seen during EVAL stays pending.
    always_comb begin
        rcnt_tick = rcnt;
        if (frame_tick && (st == S_ARMED || st == S_EVAL) && rcnt != TO_L)
            rcnt_tick = rcnt + 10'd1;
    end
    assign timed_out = (rcnt_tick == TO_L);
`else
    localparam int unused_timeout = TIMEOUT_FRAMES;
    assign timed_out = 1'b0;
`endif

    always_comb begin
        st_nxt      = st;
        shots_nxt   = shots_left;
        round_nxt   = round_num;
        score_nxt   = score;
        miss_nxt    = miss_cnt;
        fcnt_nxt    = fcnt_inc;
        respawn_nxt = 1'b0;
        case (st)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    st_nxt      = S_ARMED;
                    shots_nxt   = SHOTS_L;
                    round_nxt   = ROUND_W'(1);
                    score_nxt   = '0;
                    miss_nxt    = '0;
                    respawn_nxt = 1'b1;
                end
            end
            S_ARMED: begin
                if (shot) begin
                    st_nxt    = S_EVAL;
                    shots_nxt = shots_left - SHOT_W'(1);
                    fcnt_nxt  = '0;
                end else if (timed_out) begin
                    st_nxt    = S_MISS;
                    shots_nxt = '0;
                    miss_nxt  = sat_inc_miss(miss_cnt);
                    fcnt_nxt  = '0;
                end
            end
            S_EVAL: begin
                // A hit takes priority over the evaluation window closing.
                if (rect_clicked) begin
                    st_nxt    = S_HIT;
                    score_nxt = sat_inc_score(score);
                    fcnt_nxt  = '0;
                end else if (frame_tick && fcnt_inc == EVAL_L) begin
                    if (shots_left == '0 || timed_out) begin
                        st_nxt    = S_MISS;
                        shots_nxt = '0;
                        miss_nxt  = sat_inc_miss(miss_cnt);
                        fcnt_nxt  = '0;
                    end else begin
                        st_nxt = S_ARMED;
                    end
                end
            end
            S_HIT, S_MISS: begin
                if (frame_tick && fcnt_inc == HOLD_L) begin
                    if (round_num == ROUNDS_L) begin
                        st_nxt = S_GAME_OVER;
                    end else begin
                        st_nxt      = S_ARMED;
                        round_nxt   = round_num + ROUND_W'(1);
                        shots_nxt   = SHOTS_L;
                        respawn_nxt = 1'b1;
                    end
                end
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            st           <= S_IDLE;
            shots_left   <= '0;
            round_num    <= '0;
            score        <= '0;
            miss_cnt     <= '0;
            hit_flash    <= 1'b0;
            duck_respawn <= 1'b0;
            game_over    <= 1'b0;
            fcnt         <= '0;
`ifdef DUCK_ROUND_TIMEOUT_EN
            rcnt         <= '0;
`endif
        end else begin
            st           <= st_nxt;
            shots_left   <= shots_nxt;
            round_num    <= round_nxt;
            score        <= score_nxt;
            miss_cnt     <= miss_nxt;
            hit_flash    <= (st_nxt == S_HIT);
            duck_respawn <= respawn_nxt;
            game_over    <= (st_nxt == S_GAME_OVER);
            fcnt         <= fcnt_nxt;
`ifdef DUCK_ROUND_TIMEOUT_EN
            rcnt         <= respawn_nxt ? 10'd0 : rcnt_tick;
`endif
        end
    end

    assign state = st;

endmodule
